// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..max_val with load, enable, wrap/saturate and a registered terminal-count pulse.
// Optional prescaler enabled by defining CNT_PRESCALE_EN (adds the presc_div input).
module updown_mod_counter #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b1}},
  parameter int               PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic                  sat_mode,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic                  at_bound
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic             tick;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

`ifdef CNT_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  logic [PRESCALE_W-1:0] presc;

  assign tick = (presc == presc_div);

  // Prescaler advances only while enabled, so its phase survives en gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc <= '0;
    else if (load) presc <= '0;
    else if (en)   presc <= tick ? '0 : presc + PONE;
  end
`else
  // No prescaler: every enabled cycle is a step (PRESCALE_W is always >= 1).
  assign tick = (PRESCALE_W > 0);
`endif

  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = clamp(load_val, max_val);
    end else if (en && tick) begin
      if (q > max_val) begin
        // Out of range (max_val lowered or reset value): re-enter without a wrap report.
        q_nxt = up ? '0 : max_val;
      end else if (up) begin
        if (q == max_val) begin
          if (!sat_mode) begin
            q_nxt  = '0;
            tc_nxt = 1'b1;
          end
        end else begin
          q_nxt  = q + ONE;
          tc_nxt = sat_mode && (q_nxt == max_val);
        end
      end else begin
        if (q == '0) begin
          if (!sat_mode) begin
            q_nxt  = max_val;
            tc_nxt = 1'b1;
          end
        end else begin
          q_nxt  = q - ONE;
          tc_nxt = sat_mode && (q_nxt == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= RESET_VAL;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

  assign at_bound = up ? (q == max_val) : (q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised scoreboard bench for updown_mod_counter against an arithmetic reference model.
// Define CNT_PRESCALE_EN for both files to exercise the prescaler.
module tb_updown_mod_counter;
  localparam int W = 4;
  localparam int RESET_V = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, up = 1'b0, load = 1'b0, sat_mode = 1'b0;
  logic [W-1:0] load_val = '0, max_val = 4'd15;
  logic [W-1:0] q;
  logic         tc, at_bound;
`ifdef CNT_PRESCALE_EN
  logic [3:0]   presc_div = '0;
`endif

  updown_mod_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val), .sat_mode(sat_mode),
`ifdef CNT_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .q(q), .tc(tc), .at_bound(at_bound)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] q; logic tc; logic ab; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0, cycle = 0;
  int m_q = RESET_V, m_tc = 0, m_p = 0;

  // Reference model: counter value as an integer on the ring/segment 0..max.
  task automatic model_edge();
    int mx, nq, ntc;
    bit tick;
    mx = int'(max_val);
`ifdef CNT_PRESCALE_EN
    tick = (m_p == int'(presc_div));
`else
    tick = 1'b1;
`endif
    if (reset) begin
      m_q = RESET_V; m_tc = 0; m_p = 0;
      return;
    end
    nq = m_q; ntc = 0;
    if (load) begin
      nq = (int'(load_val) < mx) ? int'(load_val) : mx;
      m_p = 0;
    end else if (en) begin
`ifdef CNT_PRESCALE_EN
      m_p = tick ? 0 : (m_p + 1) % 16;
`endif
      if (tick) begin
        if (m_q > mx) nq = up ? 0 : mx;
        else if (!sat_mode) begin
          nq  = up ? (m_q + 1) % (mx + 1) : (m_q + mx) % (mx + 1);
          ntc = up ? int'(m_q == mx) : int'(m_q == 0);
        end else begin
          nq  = up ? ((m_q + 1 > mx) ? mx : m_q + 1) : ((m_q == 0) ? 0 : m_q - 1);
          ntc = (nq != m_q) && (nq == (up ? mx : 0));
        end
      end
    end
    m_q = nq; m_tc = ntc;
  endtask

  task automatic cyc(int n = 1);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(posedge clk);
      model_edge();
      e.q  = W'(m_q);
      e.tc = (m_tc != 0);
      e.ab = up ? (m_q == int'(max_val)) : (m_q == 0);
      sb.push_back(e);
      cycle++;
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (q !== e.q || tc !== e.tc || at_bound !== e.ab) begin
          failures++;
          $display("FAIL cyc%0d q/tc/at_bound got %0d/%0b/%0b expected %0d/%0b/%0b",
                   cycle, q, tc, at_bound, e.q, e.tc, e.ab);
        end
      end
    end
  end

  task automatic do_load(int v);
    load = 1'b1; load_val = W'(v);
    cyc();
    load = 1'b0;
  endtask

  initial begin : stimulus
    // Reset default: down count from top with 16-cycle wrap period.
    max_val = 4'd15; up = 1'b0; en = 1'b1; sat_mode = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(34);

    // Up wrap through 0..9.
    max_val = 4'd9; up = 1'b1;
    do_load(0);
    cyc(22);

    // Saturate up to 5, hold, then count down.
    sat_mode = 1'b1; max_val = 4'd5;
    do_load(3);
    cyc(4);
    up = 1'b0;
    cyc(3);

    // Load clamp, then load colliding with a wrap step.
    sat_mode = 1'b0; max_val = 4'd7; up = 1'b1;
    do_load(12);
    do_load(2);
    do_load(7);
    do_load(2);
    cyc(2);

    // Out of range after lowering max_val, both directions.
    max_val = 4'd15;
    do_load(12);
    max_val = 4'd8;
    cyc(2);
    max_val = 4'd15;
    do_load(13);
    max_val = 4'd8; up = 1'b0;
    cyc(2);

    // Async reset asserted between edges takes effect immediately.
    up = 1'b1;
    cyc(3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (q !== 4'd15 || tc !== 1'b0) begin
      failures++;
      $display("FAIL async_reset q/tc got %0d/%0b expected 15/0", q, tc);
    end
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // max_val = 0 and 1 in both modes.
    for (int s = 0; s < 2; s++) begin
      sat_mode = s[0];
      max_val = 4'd0; do_load(0); cyc(4);
      up = 1'b0; cyc(2);
      max_val = 4'd1; cyc(5);
      up = 1'b1; cyc(5);
    end

`ifdef CNT_PRESCALE_EN
    // Prescale by 3 with an en gap to show phase retention.
    sat_mode = 1'b0; max_val = 4'd15; up = 1'b1; presc_div = 4'd2;
    do_load(0);
    cyc(7);
    en = 1'b0; cyc(2);
    en = 1'b1; cyc(8);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 11) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)  up = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) sat_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) max_val = W'($urandom_range(0, 15));
`ifdef CNT_PRESCALE_EN
      if ($urandom_range(0, 39) == 0) presc_div = 4'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1; cyc(); reset = 1'b0;
      end else begin
        cyc();
      end
      load = 1'b0;
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
